// File: rtl/adf4351_spi_sequencer.sv
// rtl/adf4351_spi_sequencer.sv - ADF4351 3-wire register loader with lock-detect wait
module adf4351_spi_sequencer #(
  parameter int          CLK_DIV      = 4,
  parameter int          LE_CYCLES    = 4,
  parameter int          GAP_CYCLES   = 4,
  parameter int          LOCK_STABLE  = 16,
  parameter int          LOCK_TIMEOUT = 100000,
  parameter logic [31:0] REG_R1       = 32'h08008011,
  parameter logic [31:0] REG_R2       = 32'h00004E42,
  parameter logic [31:0] REG_R3       = 32'h000004B3,
  parameter logic [31:0] REG_R5       = 32'h00580005
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        FULL_INIT,
  input  logic [31:0] ADF_R0,
  input  logic [31:0] ADF_R4,
  input  logic        LD,
  output logic        SCLK,
  output logic        SDATA,
  output logic        LE,
  output logic        BUSY,
  output logic        DONE,
  output logic        LOCKED,
  output logic        TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LE_PULSE, S_GAP, S_WAIT_LOCK, S_FINISH
  } state_t;

  localparam logic [31:0] DIV_LAST     = 32'(CLK_DIV - 1);
  localparam logic [31:0] LE_LAST      = 32'(LE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] timer;
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic [2:0]  word_idx;
  logic        full_seq;
  logic        init_done;
  logic [31:0] r0_q, r4_q;
  logic        ld_meta, ld_sync;
  logic [31:0] stable;
  logic        last_word;
  logic        lock_hit, timeout_hit;
  logic [31:0] next_word;

  assign last_word = full_seq ? (word_idx == 3'd5) : (word_idx == 3'd1);

  // Full list goes out R5 first so R0 (which triggers VCO calibration) lands last
  always_comb begin
    next_word = r0_q;
    if (full_seq) begin
      case (word_idx)
        3'd0:    next_word = REG_R5;
        3'd1:    next_word = r4_q;
        3'd2:    next_word = REG_R3;
        3'd3:    next_word = REG_R2;
        3'd4:    next_word = REG_R1;
        default: next_word = r0_q;
      endcase
    end else if (word_idx == 3'd0) begin
      next_word = r4_q;
    end
  end

  always_comb begin
    state_n     = state;
    lock_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:     if (START) state_n = S_LOAD;
      S_LOAD:     state_n = S_SHIFT_LO;
      S_SHIFT_LO: if (timer == DIV_LAST) state_n = S_SHIFT_HI;
      S_SHIFT_HI: if (timer == DIV_LAST) state_n = (bit_cnt == 5'd0) ? S_LE_PULSE : S_SHIFT_LO;
      S_LE_PULSE: if (timer == LE_LAST) state_n = S_GAP;
      S_GAP:      if (timer == GAP_LAST) state_n = last_word ? S_WAIT_LOCK : S_LOAD;
      S_WAIT_LOCK: begin
        // Lock is checked first so it wins a tie with the timeout
        if (ld_sync && stable == STABLE_LAST) begin
          lock_hit = 1'b1;
          state_n  = S_FINISH;
        end else if (timer == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_n     = S_FINISH;
        end
      end
      S_FINISH:   state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  assign SCLK  = (state == S_SHIFT_HI);
  assign SDATA = ((state == S_SHIFT_LO) || (state == S_SHIFT_HI)) && shreg[31];
  assign LE    = (state == S_LE_PULSE);
  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_FINISH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ld_meta <= 1'b0;
      ld_sync <= 1'b0;
    end else begin
      ld_meta <= LD;
      ld_sync <= ld_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer     <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_idx  <= '0;
      full_seq  <= 1'b0;
      init_done <= 1'b0;
      r0_q      <= '0;
      r4_q      <= '0;
      stable    <= '0;
      LOCKED    <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      timer  <= (state_n != state || state == S_IDLE) ? 32'd0 : timer + 32'd1;
      stable <= '0;
      case (state)
        S_IDLE: begin
          if (START) begin
            r0_q     <= ADF_R0;
            r4_q     <= ADF_R4;
            LOCKED   <= 1'b0;
            TIMEOUT  <= 1'b0;
            full_seq <= FULL_INIT || !init_done;
            word_idx <= '0;
          end
        end
        S_LOAD: begin
          shreg   <= next_word;
          bit_cnt <= 5'd31;
        end
        S_SHIFT_HI: begin
          if (timer == DIV_LAST) begin
            shreg <= {shreg[30:0], 1'b0};
            if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST && !last_word) word_idx <= word_idx + 3'd1;
        end
        S_WAIT_LOCK: begin
          stable <= ld_sync ? stable + 32'd1 : 32'd0;
          if (lock_hit)         LOCKED  <= 1'b1;
          else if (timeout_hit) TIMEOUT <= 1'b1;
        end
        S_FINISH: init_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
